// File: rtl/nsum_inv.sv
// Iterative inverse N-sum: recovers the largest N with N(N+1)/2 <= S and the remainder.
// Optional zero-bubble job chaining when NSUM_INV_PIPE_EN is defined.
module nsum_inv #(
    parameter int SUM_W = 5,
    parameter int N_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] s_in,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [N_W-1:0]   n_out,
    output logic [SUM_W-1:0] rem_out,
    output logic             exact,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = (SUM_W > N_W + 1) ? SUM_W : N_W + 1;

    localparam logic [N_W:0] NMAX  = {1'b0, {N_W{1'b1}}};
    localparam logic [N_W:0] I_END = {1'b1, {N_W{1'b0}}};
    localparam logic [N_W:0] I_ONE = {{N_W{1'b0}}, 1'b1};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [SUM_W-1:0] rem_q,       rem_d;
    logic [N_W:0]     i_q,         i_d;
    logic [N_W-1:0]   n_q,         n_d;
    logic [N_W-1:0]   n_out_q,     n_out_d;
    logic [SUM_W-1:0] rem_out_q,   rem_out_d;
    logic             exact_q,     exact_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [CW-1:0] rem_ext;
    logic [CW-1:0] i_ext;
    logic          fits;
    logic          accept;

    // Compare in a common width so neither operand wraps.
    assign rem_ext = CW'(rem_q);
    assign i_ext   = CW'(i_q);
    assign fits    = (rem_ext >= i_ext);

`ifdef NSUM_INV_PIPE_EN
    assign s_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
    assign s_ready = (state_q == IDLE);
`endif

    assign accept = s_valid && s_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        rem_d       = rem_q;
        i_d         = i_q;
        n_d         = n_q;
        n_out_d     = n_out_q;
        rem_out_d   = rem_out_q;
        exact_d     = exact_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d   = s_in;
                    i_d     = I_ONE;
                    n_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fits && (i_q <= NMAX)) begin
                    // rem >= i guarantees i fits in SUM_W bits, so the cast is lossless.
                    rem_d = rem_q - SUM_W'(i_q);
                    n_d   = i_q[N_W-1:0];
                    i_d   = i_q + I_ONE;
                end else begin
                    n_out_d     = n_q;
                    rem_out_d   = rem_q;
                    exact_d     = (rem_q == '0);
                    ovf_d       = (i_q == I_END) && fits;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef NSUM_INV_PIPE_EN
                    if (accept) begin
                        rem_d   = s_in;
                        i_d     = I_ONE;
                        n_d     = '0;
                        state_d = RUN;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            i_q         <= '0;
            n_q         <= '0;
            n_out_q     <= '0;
            rem_out_q   <= '0;
            exact_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            i_q         <= i_d;
            n_q         <= n_d;
            n_out_q     <= n_out_d;
            rem_out_q   <= rem_out_d;
            exact_q     <= exact_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign n_out     = n_out_q;
    assign rem_out   = rem_out_q;
    assign exact     = exact_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nsum_inv.sv
// Bench for nsum_inv: a 5-bit and a 6-bit instance share one stimulus stream and are
// checked against an arithmetic reference model (follows NSUM_INV_PIPE_EN if defined).
module tb_nsum_inv;

    logic       clk;
    logic       rst_n;
    logic [5:0] s_in6;
    logic [4:0] s_in5;
    logic       s_valid;
    logic       out_ready;

    logic       s_ready5, exact5, ovf5, out_valid5;
    logic [2:0] n_out5;
    logic [4:0] rem_out5;
    logic       s_ready6, exact6, ovf6, out_valid6;
    logic [2:0] n_out6;
    logic [5:0] rem_out6;

    int checks = 0;
    int errors = 0;

    assign s_in5 = s_in6[4:0];

    nsum_inv #(.SUM_W(5), .N_W(3)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .s_in(s_in5), .s_valid(s_valid), .s_ready(s_ready5),
        .n_out(n_out5), .rem_out(rem_out5), .exact(exact5), .ovf(ovf5),
        .out_valid(out_valid5), .out_ready(out_ready)
    );

    nsum_inv #(.SUM_W(6), .N_W(3)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .s_in(s_in6), .s_valid(s_valid), .s_ready(s_ready6),
        .n_out(n_out6), .rem_out(rem_out6), .exact(exact6), .ovf(ovf6),
        .out_valid(out_valid6), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Largest N (capped at nmax) whose triangular number fits in s.
    function automatic void model(input int s, input int nmax,
                                  output int n, output int rem, output int ov);
        n = 0;
        while (n < nmax && ((n + 1) * (n + 2)) / 2 <= s) n++;
        rem = s - (n * (n + 1)) / 2;
        ov  = (n == nmax && rem >= nmax + 1) ? 1 : 0;
    endfunction

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(s_ready5 && s_ready6) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("idle_ready", {31'd0, s_ready5 & s_ready6}, 32'd1);
    endtask

    task automatic run_job(input int s6, input int stall);
        int n5, r5, o5, n6, r6, o6, cyc, lat5, lat6;
        model(s6 & 31, 7, n5, r5, o5);
        model(s6, 7, n6, r6, o6);
        wait_ready();
        out_ready = 1'b0;
        s_in6     = 6'(s6);
        s_valid   = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        cyc  = 0;
        lat5 = -1;
        lat6 = -1;
        while (cyc < 40) begin
            if (out_valid5 && lat5 < 0) lat5 = cyc;
            if (out_valid6 && lat6 < 0) lat6 = cyc;
            if (lat5 >= 0 && lat6 >= 0) break;
            @(negedge clk);
            cyc++;
        end
        if (lat5 < 0 || lat6 < 0) begin
            check("timeout_out_valid", 32'd0, 32'd1);
            return;
        end
        check("lat5",   lat5,     n5 + 1);
        check("lat6",   lat6,     n6 + 1);
        check("n5",     n_out5,   n5);
        check("rem5",   rem_out5, r5);
        check("exact5", exact5,   (r5 == 0) ? 1 : 0);
        check("ovf5",   ovf5,     o5);
        check("n6",     n_out6,   n6);
        check("rem6",   rem_out6, r6);
        check("exact6", exact6,   (r6 == 0) ? 1 : 0);
        check("ovf6",   ovf6,     o6);
        check("done_ready5", s_ready5, 0);
        for (int k = 0; k < stall; k++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_in6   = 6'($urandom_range(0, 63));
            @(negedge clk);
            check("hold_valid5", out_valid5, 1);
            check("hold_n5",     n_out5,     n5);
            check("hold_rem5",   rem_out5,   r5);
            check("hold_rem6",   rem_out6,   r6);
            check("hold_ready5", s_ready5,   0);
            check("hold_ready6", s_ready6,   0);
        end
        s_valid   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ho_valid5", out_valid5, 0);
        check("ho_valid6", out_valid6, 0);
        check("ho_idle5",  s_ready5,   1);
        check("ho_keep_n5", n_out5,    n5);
        check("ho_keep_rem6", rem_out6, r6);
    endtask

    task automatic back_to_back();
        int cyc, accepts, ho_cyc;
        int acc_cyc[2];
        int res_n[$];
        int res_r[$];
        wait_ready();
        out_ready = 1'b1;
        s_in6     = 6'd3;
        s_valid   = 1'b1;
        cyc       = 0;
        accepts   = 0;
        ho_cyc    = -1;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        while (cyc < 60 && res_n.size() < 2) begin
            if (out_valid5 && out_ready) begin
                res_n.push_back(int'(n_out5));
                res_r.push_back(int'(rem_out5));
                if (ho_cyc < 0) ho_cyc = cyc;
            end
            if (s_valid && s_ready5 && accepts < 2) begin
                acc_cyc[accepts] = cyc;
                accepts++;
            end
            @(negedge clk);
            cyc++;
            if (accepts == 1) s_in6 = 6'd15;
            if (accepts == 2) s_valid = 1'b0;
        end
        s_valid   = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", res_n.size(), 2);
        if (res_n.size() == 2) begin
            check("b2b_n0", res_n[0], 2);
            check("b2b_r0", res_r[0], 0);
            check("b2b_n1", res_n[1], 5);
            check("b2b_r1", res_r[1], 0);
        end
`ifdef NSUM_INV_PIPE_EN
        check("b2b_gap", acc_cyc[1], ho_cyc);
`else
        check("b2b_gap", acc_cyc[1], ho_cyc + 1);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        s_in6     = '0;
        s_valid   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid5", out_valid5, 0);
        check("rst_n5",     n_out5,     0);
        check("rst_rem6",   rem_out6,   0);
        check("rst_ready5", s_ready5,   1);
        rst_n = 1'b1;

        run_job(28, 0);
        run_job(20, 1);
        run_job(0, 0);
        run_job(40, 0);
        run_job(31, 2);
        run_job(10, 5);
        run_job(63, 1);

        // Abort a long job with a one-cycle reset pulse.
        wait_ready();
        s_in6   = 6'd28;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid5", out_valid5, 0);
        check("abort_n5",     n_out5,     0);
        check("abort_rem5",   rem_out5,   0);
        check("abort_ovf6",   ovf6,       0);
        check("abort_n6",     n_out6,     0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_valid", out_valid5 | out_valid6, 0);
        run_job(6, 0);

        back_to_back();

        for (int j = 0; j < 15; j++) begin
            run_job(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
